// File: rtl/ysyx_25040109_lsu_if.sv
// Data-memory port of the LSU: one request channel and one response channel.
// The LSU uses the master modport and the memory model or bus bridge uses the slave modport.
interface ysyx_25040109_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_25040109_lsu.sv
// Multi-cycle load/store unit: one word-aligned memory request per operation.
// Misalignment, illegal widths, bus errors and timeouts retire as faults.
module ysyx_25040109_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_funct3,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [4:0]  in_rd_addr,
    ysyx_25040109_lsu_if.master mem,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd_addr,
    output logic        out_reg_we,
    output logic        out_fault
);
    // state  | meaning
    // S_IDLE | waiting for an operation from execute
    // S_REQ  | memory request held until accepted
    // S_RESP | waiting for the memory response
    // S_DONE | result presented to write-back
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t r_state, w_state_nxt;

    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic [2:0]    r_funct3;
    logic          r_is_load, r_is_store, r_fault, r_reg_we;
    logic [4:0]    r_rd_addr;
    logic [CW-1:0] r_cnt;

    logic        w_accept, w_busy, w_tc, w_f3_bad, w_misalign, w_fault_acc, w_noop;
    logic        w_req_hs, w_resp_hs;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data, w_wdata;
    logic [3:0]  w_wstrb;

    always_comb begin
        w_f3_bad = 1'b0;
        if (in_is_load) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_bad = 1'b0;
                default:                                 w_f3_bad = 1'b1;
            endcase
        end else begin
            w_f3_bad = in_funct3[2] || (in_funct3[1:0] == 2'b11);
        end
    end

    assign w_misalign  = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                         ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    assign w_noop      = !in_is_load && !in_is_store;
    assign w_fault_acc = (in_is_load && in_is_store) || (!w_noop && (w_f3_bad || w_misalign));
    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_busy      = (r_state == S_REQ) || (r_state == S_RESP);
    assign w_tc        = (TIMEOUT != 0) && w_busy && (r_cnt == TC);
    assign w_req_hs    = (r_state == S_REQ) && mem.mem_req_ready;
    assign w_resp_hs   = (r_state == S_RESP) && mem.mem_resp_valid;

    // Lane selection uses the latched address; the request is always word-aligned.
    assign w_byte = mem.mem_resp_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = mem.mem_resp_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem.mem_resp_rdata;
        endcase
    end

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'd0;
        if (r_is_store) begin
            case (r_funct3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << r_addr[1:0];
                    w_wdata = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    w_wstrb = 4'b0011 << {r_addr[1], 1'b0};
                    w_wdata = {2{r_wdata[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = r_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt        = r_state;
        in_ready           = 1'b0;
        mem.mem_req_valid  = 1'b0;
        mem.mem_req_we     = 1'b0;
        mem.mem_req_addr   = 32'd0;
        mem.mem_req_wdata  = 32'd0;
        mem.mem_req_wstrb  = 4'b0000;
        mem.mem_resp_ready = 1'b0;
        out_valid          = 1'b0;
        out_rdata          = 32'd0;
        out_rd_addr        = 5'd0;
        out_reg_we         = 1'b0;
        out_fault          = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = (w_noop || w_fault_acc) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_we    = r_is_store;
                mem.mem_req_addr  = {r_addr[31:2], 2'b00};
                mem.mem_req_wdata = w_wdata;
                mem.mem_req_wstrb = w_wstrb;
                if (mem.mem_req_ready) w_state_nxt = S_RESP;
                else if (w_tc)         w_state_nxt = S_DONE;
            end
            S_RESP: begin
                mem.mem_resp_ready = 1'b1;
                if (mem.mem_resp_valid || w_tc) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid   = 1'b1;
                out_rdata   = r_rdata;
                out_rd_addr = r_rd_addr;
                out_reg_we  = r_reg_we;
                out_fault   = r_fault;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_funct3   <= 3'd0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_rd_addr  <= 5'd0;
            r_cnt      <= '0;
            r_fault    <= 1'b0;
            r_rdata    <= 32'd0;
            r_reg_we   <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= in_addr;
            r_wdata    <= in_wdata;
            r_funct3   <= in_funct3;
            r_is_load  <= in_is_load;
            r_is_store <= in_is_store;
            r_rd_addr  <= in_rd_addr;
            r_cnt      <= '0;
            r_fault    <= w_fault_acc;
            r_rdata    <= 32'd0;
            r_reg_we   <= 1'b0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + CW'(1);
            // A handshake in the terminal-count cycle takes priority over the timeout.
            if (w_resp_hs) begin
                r_fault  <= mem.mem_resp_err;
                r_rdata  <= (mem.mem_resp_err || !r_is_load) ? 32'd0 : w_load_data;
                r_reg_we <= !mem.mem_resp_err && r_is_load && (r_rd_addr != 5'd0);
            end else if (w_tc && !w_req_hs) begin
                r_fault <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Scoreboard bench for the LSU: expected results are queued at issue and
// compared when out_valid appears.
module tb_ysyx_25040109_lsu;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_is_load = 1'b0, in_is_store = 1'b0;
    logic [31:0] in_addr = '0, in_wdata = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd_addr = '0;
    logic        in_ready, out_valid, out_reg_we, out_fault;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd_addr;

    ysyx_25040109_lsu_if mem_if();

    ysyx_25040109_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_funct3(in_funct3), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_rd_addr(in_rd_addr), .mem(mem_if),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_rd_addr(out_rd_addr), .out_reg_we(out_reg_we), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        we;
        logic        fault;
    } res_t;

    res_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int req_wait, input int resp_wait,
                          input logic [31:0] rdata, input logic err, input bit no_resp,
                          input int hold, input int exp_lat);
        logic [1:0]  w, off;
        logic        bad_f3, mis, acc_fault, issue;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, lv, b, h;
        res_t        e, got;
        int          lat;
        w   = f3[1:0];
        off = addr[1:0];
        bad_f3    = ld ? (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 > 3'd2);
        mis       = (w == 2'd1 && addr[0]) || (w == 2'd2 && off != 2'd0);
        acc_fault = (ld && st) || ((ld || st) && (bad_f3 || mis));
        issue     = (ld || st) && !acc_fault;
        e_strb  = 4'b0000;
        e_wdata = 32'd0;
        if (st) begin
            case (w)
                2'd0: begin
                    e_strb  = 4'b0001 << off;
                    e_wdata = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
                end
                2'd1: begin
                    e_strb  = off[1] ? 4'b1100 : 4'b0011;
                    e_wdata = {wdata[15:0], wdata[15:0]};
                end
                default: begin
                    e_strb  = 4'b1111;
                    e_wdata = wdata;
                end
            endcase
        end
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    lv = b[7]  ? (b | 32'hFFFFFF00) : b;
            3'd1:    lv = h[15] ? (h | 32'hFFFF0000) : h;
            3'd4:    lv = b;
            3'd5:    lv = h;
            default: lv = rdata;
        endcase
        e.rd = rd;
        if (acc_fault || (issue && (no_resp || err))) begin
            e.fault = 1'b1; e.rdata = 32'd0; e.we = 1'b0;
        end else if (!issue) begin
            e.fault = 1'b0; e.rdata = 32'd0; e.we = 1'b0;
        end else begin
            e.fault = 1'b0; e.rdata = st ? 32'd0 : lv; e.we = ld && (rd != 5'd0);
        end
        sb.push_back(e);

        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wdata; in_rd_addr = rd;
        @(negedge clk);
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        lat = 1;
        chk("in_ready_busy", in_ready, 0);
        if (issue) begin
            chk("req_valid", mem_if.mem_req_valid, 1);
            chk("req_addr", mem_if.mem_req_addr, {addr[31:2], 2'b00});
            chk("req_we", mem_if.mem_req_we, st);
            chk("req_wstrb", mem_if.mem_req_wstrb, e_strb);
            chk("req_wdata", mem_if.mem_req_wdata, e_wdata);
            for (int i = 0; i < req_wait; i++) begin
                @(negedge clk); lat++;
                chk("req_hold_valid", mem_if.mem_req_valid, 1);
                chk("req_hold_addr", mem_if.mem_req_addr, {addr[31:2], 2'b00});
                chk("req_hold_wstrb", mem_if.mem_req_wstrb, e_strb);
                chk("req_hold_wdata", mem_if.mem_req_wdata, e_wdata);
            end
            mem_if.mem_req_ready = 1'b1;
            @(negedge clk); lat++;
            mem_if.mem_req_ready = 1'b0;
            chk("req_dropped", mem_if.mem_req_valid, 0);
            chk("resp_ready", mem_if.mem_resp_ready, 1);
            if (!no_resp) begin
                for (int i = 0; i < resp_wait; i++) begin
                    @(negedge clk); lat++;
                end
                mem_if.mem_resp_valid = 1'b1; mem_if.mem_resp_rdata = rdata; mem_if.mem_resp_err = err;
                @(negedge clk); lat++;
                mem_if.mem_resp_valid = 1'b0; mem_if.mem_resp_err = 1'b0;
            end
        end else begin
            chk("no_req", mem_if.mem_req_valid, 0);
        end
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(negedge clk); lat++;
        end
        chk("out_valid", out_valid, 1);
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        got = sb.pop_front();
        chk("out_rdata", out_rdata, got.rdata);
        chk("out_rd_addr", out_rd_addr, got.rd);
        chk("out_reg_we", out_reg_we, got.we);
        chk("out_fault", out_fault, got.fault);
        // A response arriving after a timeout must not disturb the retired result.
        if (no_resp) begin
            mem_if.mem_resp_valid = 1'b1; mem_if.mem_resp_rdata = 32'hFFFF_FFFF;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_rdata", out_rdata, got.rdata);
            chk("hold_we", out_reg_we, got.we);
            chk("hold_fault", out_fault, got.fault);
        end
        mem_if.mem_resp_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("retire_valid", out_valid, 0);
        chk("retire_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_rdata = 32'd0; mem_if.mem_resp_err = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", mem_if.mem_req_valid, 0);
        chk("rst_resp_ready", mem_if.mem_resp_ready, 0);
        @(negedge clk); rst_n = 1'b1;

        //      ld    st    f3    addr          wdata         rd  rqw rsw rdata         err   nr    hold lat
        run_op(1'b1, 1'b0, 3'd2, 32'h8000_0004, 32'd0,        5,  0,  0,  32'hDEAD_BEEF, 1'b0, 1'b0, 0,   3);
        run_op(1'b1, 1'b0, 3'd0, 32'h8000_0003, 32'd0,        6,  0,  0,  32'h80FF_7F01, 1'b0, 1'b0, 0,   3);
        run_op(1'b1, 1'b0, 3'd5, 32'h8000_0002, 32'd0,        7,  0,  1,  32'h80FF_7F01, 1'b0, 1'b0, 0,   4);
        run_op(1'b1, 1'b0, 3'd1, 32'h8000_0002, 32'd0,        8,  1,  0,  32'h80FF_7F01, 1'b0, 1'b0, 0,   4);
        run_op(1'b1, 1'b0, 3'd4, 32'h8000_0001, 32'd0,        9,  0,  0,  32'h80FF_7F01, 1'b0, 1'b0, 0,   3);
        run_op(1'b0, 1'b1, 3'd1, 32'h1000_0002, 32'h1234_ABCD, 0, 5,  0,  32'd0,         1'b0, 1'b0, 0,   8);
        run_op(1'b0, 1'b1, 3'd0, 32'h1000_0001, 32'h0000_0055, 0, 0,  0,  32'd0,         1'b0, 1'b0, 0,   3);
        run_op(1'b0, 1'b1, 3'd2, 32'h1000_0008, 32'hCAFE_F00D, 0, 0,  2,  32'd0,         1'b0, 1'b0, 0,   5);
        run_op(1'b1, 1'b0, 3'd2, 32'h8000_0001, 32'd0,        3,  0,  0,  32'd0,         1'b0, 1'b0, 0,   1);
        run_op(1'b0, 1'b1, 3'd3, 32'h1000_0000, 32'd0,        0,  0,  0,  32'd0,         1'b0, 1'b0, 0,   1);
        run_op(1'b1, 1'b0, 3'd6, 32'h1000_0000, 32'd0,        4,  0,  0,  32'd0,         1'b0, 1'b0, 0,   1);
        run_op(1'b1, 1'b0, 3'd1, 32'h8000_0003, 32'd0,        4,  0,  0,  32'd0,         1'b0, 1'b0, 0,   1);
        run_op(1'b1, 1'b1, 3'd2, 32'h8000_0000, 32'd0,        4,  0,  0,  32'd0,         1'b0, 1'b0, 0,   1);
        run_op(1'b0, 1'b0, 3'd2, 32'h8000_0000, 32'd0,        4,  0,  0,  32'd0,         1'b0, 1'b0, 0,   1);
        run_op(1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'd0,        0,  0,  0,  32'h1111_2222, 1'b0, 1'b0, 0,   3);
        run_op(1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'd0,        12, 0,  0,  32'h1111_2222, 1'b1, 1'b0, 0,   3);
        run_op(1'b1, 1'b0, 3'd2, 32'h8000_0010, 32'd0,        13, 0,  0,  32'd0,         1'b0, 1'b1, 2,   9);
        run_op(1'b1, 1'b0, 3'd0, 32'h8000_0000, 32'd0,        14, 0,  0,  32'h0000_00F0, 1'b0, 1'b0, 3,   3);

        for (int k = 0; k < 8; k++) begin
            logic [2:0]  f3r;
            logic [31:0] ar;
            logic        isst;
            isst = $urandom_range(0, 1) == 1;
            f3r  = isst ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            if (f3r == 3'd3) f3r = 3'd4;
            ar   = $urandom;
            if (f3r[1:0] == 2'd1) ar[0] = 1'b0;
            if (f3r[1:0] == 2'd2) ar[1:0] = 2'b00;
            run_op(!isst, isst, f3r, ar, $urandom, 5'($urandom_range(1, 31)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0, 1'b0, 0, -1);
        end

        // A stray response while idle must not produce a result.
        @(negedge clk);
        mem_if.mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_if.mem_resp_valid = 1'b0;
        chk("idle_resp_ignored", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);

        // Reset asserted while waiting for a response abandons the operation.
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'd2; in_addr = 32'h8000_0020; in_rd_addr = 5'd3;
        @(negedge clk);
        in_valid = 1'b0; in_is_load = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_if.mem_req_ready = 1'b0;
        chk("pre_rst_resp_ready", mem_if.mem_resp_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_resp_ready", mem_if.mem_resp_ready, 0);
        chk("mid_rst_req_valid", mem_if.mem_req_valid, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_fault", out_fault, 0);
        chk("mid_rst_out_rdata", out_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_if.mem_resp_valid = 1'b1; mem_if.mem_resp_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        mem_if.mem_resp_valid = 1'b0;
        chk("post_rst_no_out", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_25040109_lsu.md
# ysyx_25040109_lsu

Multi-cycle load/store unit between the execute stage and the data-memory port of the ysyx_25040109 core. The execute stage supplies the computed effective address and store data. This block converts them into one word-aligned memory request with byte strobes and waits for the response. It then extracts and extends load data, and hands the result to write-back over a valid/ready handshake. Misaligned accesses, illegal width codes, bus errors and timeouts are reported as faults instead of being issued or silently retired.

## Interface
- TIMEOUT, default 255: maximum cycles spent in REQ+RESP before a fault is raised; 0 disables the timeout.

- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage presents an operation
- in_ready  out  1  LSU can accept an operation (high only in IDLE)
- in_addr  in  32  effective address (EXU result)
- in_wdata  in  32  store data (rs2)
- in_funct3  in  3  width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- in_is_load  in  1  load operation
- in_is_store  in  1  store operation
- in_rd_addr  in  5  load destination register
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write
- mem_req_addr  out  32  {in_addr[31:2], 2'b00}
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wstrb  out  4  byte enables (0000 for reads)
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  high only in RESP
- mem_resp_rdata  in  32  read word
- mem_resp_err  in  1  bus error on this response
- out_valid  out  1  result available (high only in DONE)
- out_ready  in  1  write-back accepts result
- out_rdata  out  32  extended load data; 0 for stores and faults
- out_rd_addr  out  5  latched in_rd_addr
- out_reg_we  out  1  1 only for a fault-free load with in_rd_addr != 0
- out_fault  out  1  misaligned, illegal funct3, both flags set, bus error, or timeout

## Operation
- States: IDLE, REQ, RESP, DONE. Accept on in_valid && in_ready; latch all in_* fields.
- Accept routing:
  - Neither flag set: go to DONE as a no-op with fault 0 and reg_we 0.
  - Both flags set, illegal funct3 (load 011/110/111, store other than 000–010), or misalignment (H with addr[0]=1; W with addr[1:0]!=0): go to DONE with fault 1. No memory request is issued.
  - Otherwise: go to REQ.
- REQ: mem_req_valid=1. All mem_req_* fields stay stable until mem_req_ready; the request is never withdrawn. On the handshake, go to RESP.
- RESP: mem_resp_ready=1. On mem_resp_valid, capture data and err, then go to DONE.
- DONE: out_valid=1 with outputs stable. On out_ready, go to IDLE.
- Store strobes:
  - SB: 4'b0001<<addr[1:0], wdata {4{wdata[7:0]}}.
  - SH: 4'b0011<<{addr[1],1'b0}, wdata {2{wdata[15:0]}}.
  - SW: 4'b1111, wdata unchanged.
- Load extraction: byte = rdata[8*addr[1:0] +: 8] and half = rdata[16*addr[1] +: 16]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- mem_resp_err=1: fault 1, rdata 0, reg_we 0.
- Timeout counter:
  - Clears on accept and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT (and TIMEOUT!=0), go to DONE with fault 1, deassert the request, and ignore any later response.
  - A handshake and the timeout in the same cycle: the handshake wins.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0. in_ready=1; every other output is 0. Reset mid-operation abandons the transaction with no retirement.
- Minimum load/store latency:
  - Accept edge T0, then mem_req_valid during T1.
  - If ready in T1 and resp_valid in T2, out_valid is high in T3.
- A fault detected at accept gives out_valid in the cycle after accept.
- in_ready is low from the cycle after accept until the cycle after the out handshake. Back-to-back throughput is at most one operation per 4 cycles.
- mem_resp_valid outside RESP is ignored.

## Test plan
- LW addr 0x80000004, mem returns 0xDEADBEEF with zero wait -> req addr 0x80000004, wstrb 0000; out_valid 3 cycles after accept; rdata 0xDEADBEEF, reg_we 1.
- LB addr 0x80000003, rdata 0x80FF7F01 -> out_rdata 0xFFFFFF80. LHU addr 0x80000002, same rdata -> 0x000080FF.
- SH addr 0x10000002, wdata 0x1234ABCD, mem_req_ready held low 5 cycles -> wdata 0xABCDABCD and wstrb 1100, both stable for all 5 cycles; reg_we 0, fault 0.
- LW addr 0x80000001 -> no mem_req_valid; out_valid the cycle after accept, fault 1. SB with funct3 011 -> fault 1.
- TIMEOUT=8, memory never responds -> out_valid with fault 1 after 8 cycles in REQ/RESP; a late response is ignored.
- out_ready held low 3 cycles in DONE -> outputs stable and in_ready 0 throughout. rst_n low mid-RESP -> IDLE immediately, in_ready 1, all other outputs 0.
